// File: rtl/pixel_dispatcher_if.sv
`default_nettype none
// ==========================================================================
// pixel_dispatcher_if : depth-calculator request/response + pixel stream
// Revision 1.0
// ==========================================================================
interface pixel_dispatcher_if #(
  parameter int WORD_LENGTH = 32
);
  logic                          calc_start;
  logic [10:0]                   calc_x;
  logic [10:0]                   calc_y;
  logic signed [WORD_LENGTH-1:0] calc_re_c;
  logic signed [WORD_LENGTH-1:0] calc_im_c;
  logic                          calc_done;
  logic [10:0]                   calc_depth;
  logic [10:0]                   m_data;
  logic                          m_valid;
  logic                          m_ready;
  logic                          m_sof;
  logic                          m_eol;

  modport master (
    output calc_start, calc_x, calc_y, calc_re_c, calc_im_c,
    input  calc_done, calc_depth,
    output m_data, m_valid, m_sof, m_eol,
    input  m_ready
  );

  modport slave (
    input  calc_start, calc_x, calc_y, calc_re_c, calc_im_c,
    output calc_done, calc_depth,
    input  m_data, m_valid, m_sof, m_eol,
    output m_ready
  );
endinterface
`default_nettype wire

// File: rtl/pixel_dispatcher.sv
`default_nettype none
// ==========================================================================
// pixel_dispatcher : raster-scans a frame, launches one depth calc per pixel
// Revision 1.0
// ==========================================================================
module pixel_dispatcher #(
  parameter int WORD_LENGTH = 32,
  parameter int FRAC        = 28,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          frame_go,
  input  logic signed [WORD_LENGTH-1:0] re_origin,
  input  logic signed [WORD_LENGTH-1:0] im_origin,
  input  logic signed [WORD_LENGTH-1:0] step,
  output logic                          busy,
  output logic                          frame_done,
  pixel_dispatcher_if.master            bus
);

  if (FRAC >= WORD_LENGTH) begin : g_frac_check
    $error("pixel_dispatcher: FRAC must be smaller than WORD_LENGTH");
  end

  if (H_RES < 1 || H_RES > 2047 || V_RES < 1 || V_RES > 2047) begin : g_res_check
    $error("pixel_dispatcher: H_RES and V_RES must lie in 1..2047");
  end

  localparam logic [10:0] X_LAST = 11'(H_RES - 1);
  localparam logic [10:0] Y_LAST = 11'(V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_OUTPUT    = 2'd3
  } state_t;

  state_t                        state_q,  state_d;
  logic [10:0]                   x_q,      x_d;
  logic [10:0]                   y_q,      y_d;
  logic signed [WORD_LENGTH-1:0] re_q,     re_d;
  logic signed [WORD_LENGTH-1:0] im_q,     im_d;
  logic signed [WORD_LENGTH-1:0] re_org_q, re_org_d;
  logic signed [WORD_LENGTH-1:0] step_q,   step_d;
  logic                          start_q,  start_d;
  logic [10:0]                   data_q,   data_d;
  logic                          valid_q,  valid_d;
  logic                          sof_q,    sof_d;
  logic                          eol_q,    eol_d;
  logic                          busy_q,   busy_d;
  logic                          done_q,   done_d;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      re_q     <= '0;
      im_q     <= '0;
      re_org_q <= '0;
      step_q   <= '0;
      start_q  <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      re_q     <= re_d;
      im_q     <= im_d;
      re_org_q <= re_org_d;
      step_q   <= step_d;
      start_q  <= start_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      sof_q    <= sof_d;
      eol_q    <= eol_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    re_d     = re_q;
    im_d     = im_q;
    re_org_d = re_org_q;
    step_d   = step_q;
    start_d  = 1'b0;
    data_d   = data_q;
    valid_d  = valid_q;
    sof_d    = sof_q;
    eol_d    = eol_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_go) begin
          re_org_d = re_origin;
          step_d   = step;
          x_d      = '0;
          y_d      = '0;
          re_d     = re_origin;
          im_d     = im_origin;
          start_d  = 1'b1;
          busy_d   = 1'b1;
          state_d  = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (bus.calc_done) begin
          data_d  = bus.calc_depth;
          valid_d = 1'b1;
          sof_d   = (x_q == '0) && (y_q == '0);
          eol_d   = (x_q == X_LAST);
          state_d = S_OUTPUT;
        end
      end

      S_OUTPUT: begin
        if (valid_q && bus.m_ready) begin
          valid_d = 1'b0;
          sof_d   = 1'b0;
          eol_d   = 1'b0;
          if ((x_q == X_LAST) && (y_q == Y_LAST)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            start_d = 1'b1;
            state_d = S_LAUNCH;
            // Imaginary axis runs screen-down, so each new line subtracts one step.
            if (x_q == X_LAST) begin
              x_d  = '0;
              y_d  = y_q + 11'd1;
              re_d = re_org_q;
              im_d = im_q - step_q;
            end else begin
              x_d  = x_q + 11'd1;
              re_d = re_q + step_q;
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.calc_start = start_q;
  assign bus.calc_x     = x_q;
  assign bus.calc_y     = y_q;
  assign bus.calc_re_c  = re_q;
  assign bus.calc_im_c  = im_q;
  assign bus.m_data     = data_q;
  assign bus.m_valid    = valid_q;
  assign bus.m_sof      = sof_q;
  assign bus.m_eol      = eol_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;

endmodule
`default_nettype wire

// File: doc/pixel_dispatcher.md
Name: pixel_dispatcher

Overview:
Frame-level initiator for the per-pixel depth calculator. It scans a H_RES x V_RES frame in raster order and derives each pixel's complex coordinate (re_c, im_c) incrementally from a latched origin and step. For each pixel it issues a one-cycle start, waits for done, captures the depth, and presents it on a valid/ready pixel stream with start-of-frame and end-of-line markers. It sits between the register/control block (frame parameters) and the colour-mapping/video output path.

Parameters:
WORD_LENGTH, 32, width of signed fixed-point coordinate words
FRAC, 28, fractional bits of coordinate format (Q4.28 at defaults); informational only, no arithmetic depends on it
H_RES, 640, pixels per line (1..2047)
V_RES, 480, lines per frame (1..2047)

Ports:
sysclk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_go  in  1  request a new frame; sampled only in IDLE
re_origin  in  WORD_LENGTH  signed re_c of pixel (0,0)
im_origin  in  WORD_LENGTH  signed im_c of pixel (0,0)
step  in  WORD_LENGTH  signed per-pixel coordinate delta
calc_start  out  1  one-cycle start pulse to the depth calculator
calc_x  out  11  current pixel x
calc_y  out  11  current pixel y
calc_re_c  out  WORD_LENGTH  current pixel real coordinate
calc_im_c  out  WORD_LENGTH  current pixel imaginary coordinate
calc_done  in  1  depth calculator done pulse
calc_depth  in  11  depth result, valid with calc_done
m_data  out  11  pixel depth
m_valid  out  1  stream valid
m_ready  in  1  stream ready
m_sof  out  1  first pixel of frame (x=0, y=0), qualified by m_valid
m_eol  out  1  last pixel of line (x=H_RES-1), qualified by m_valid
busy  out  1  high from LAUNCH of first pixel until frame end
frame_done  out  1  one-cycle pulse after the final pixel handshake

Behaviour:
- Reset: all outputs 0, state IDLE, x/y/coordinate registers 0. Reset mid-frame aborts immediately; no partial-frame completion; frame_done is not pulsed.
- All outputs are registered.
- States: IDLE, LAUNCH, WAIT_DONE, OUTPUT.
- IDLE: busy=0. On frame_go=1, latch re_origin, im_origin and step into shadow registers; set x=0, y=0, re=re_origin, im=im_origin; go to LAUNCH. Origin/step changes after latching have no effect until the next frame.
- LAUNCH: calc_start=1 for exactly this one cycle, then go to WAIT_DONE. calc_x, calc_y, calc_re_c and calc_im_c are stable from LAUNCH until the OUTPUT handshake.
- WAIT_DONE: on calc_done=1, register m_data=calc_depth and m_valid=1. Set m_sof=(x==0 && y==0) and m_eol=(x==H_RES-1). Go to OUTPUT. calc_done is ignored in every other state.
- OUTPUT: m_valid, m_data, m_sof and m_eol are held until m_valid && m_ready. On handshake, m_valid=0 next cycle.
  - Last pixel (x==H_RES-1 && y==V_RES-1): frame_done=1 for one cycle, busy=0, go to IDLE.
  - Else if x==H_RES-1: x=0, y=y+1, re=re_origin_latched, im=im-step.
  - Else: x=x+1, re=re+step.
  - Non-last pixels go to LAUNCH.
- Timing: frame_go in IDLE at cycle t gives calc_start at t+1. calc_done at cycle t gives m_valid at t+1. A handshake at cycle t gives the next calc_start at t+1. This guarantees at least 2 cycles between calc_done and the next calc_start.
- Arithmetic: two's complement WORD_LENGTH add/subtract, wrap on overflow, no saturation. Imaginary decreases with y (screen-down).
- frame_go while not IDLE is ignored, not queued.
- H_RES=1 or V_RES=1: every pixel has m_eol=1 (H_RES=1). The frame ends after the last pixel handshake with no extra cycles.

Test Plan:
1. Frame run: H_RES=4, V_RES=3; responder returns depth=x+y, 3 cycles after start; m_ready=1. Expect 12 pixels in raster order with data 0,1,2,3,1,2,3,4,2,3,4,5; m_sof only on pixel 0; m_eol on pixels 3, 7, 11; a single frame_done pulse; busy low afterwards.
2. Coordinates: re_origin=0xE0000000 (-2.0), im_origin=0x10000000 (1.0), step=0x04000000 (0.25). Expect pixel (3,0) re_c=0xEC000000. Expect pixel (0,2) re_c=0xE0000000 and im_c=0x08000000.
3. Backpressure: hold m_ready=0 for 10 cycles while m_valid=1. Expect m_valid/m_data/m_sof/m_eol stable and no calc_start. After m_ready=1, calc_start fires the cycle after the handshake.
4. Parameter isolation: assert frame_go and change re_origin mid-frame. Expect no restart and coordinates still derived from the latched origin.
5. Reset mid-WAIT_DONE: pulse reset, then deliver a late calc_done. Expect all outputs 0, no m_valid, no frame_done. A later frame_go restarts at (0,0) with the new origin.
6. Wrap: re_origin=0x7FFFFFF0, step=0x10, H_RES=4. Expect pixel (1,0) re_c=0x80000000, no stall.
